// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_decoder
//  Brief    : Receive-side VGA timing recovery. Rebuilds column/row counters
//             from incoming active-low HSync/VSync, flags the visible area,
//             strobes frame start and tracks lock / sync-error status.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int V_VISIBLE_AREA = 480,
    parameter int H_TOTAL        = 800,
    parameter int V_TOTAL        = 525,
    parameter int H_FRONT_PORCH  = 16,
    parameter int V_FRONT_PORCH  = 10,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_VGA_HSync,
    input  logic       i_VGA_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Visible,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_Sync_Error
);

    // Timing landmarks in counter units.
    localparam logic [9:0]  c_H_SYNC_START = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [9:0]  c_V_SYNC_START = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [9:0]  c_H_LINE_ALIGN = 10'(H_VISIBLE_AREA + H_FRONT_PORCH - 1);
    localparam logic [9:0]  c_H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  c_H_VISIBLE    = 10'(H_VISIBLE_AREA);
    localparam logic [9:0]  c_V_VISIBLE    = 10'(V_VISIBLE_AREA);
    localparam logic [3:0]  c_LOCK_FRAMES  = 4'(LOCK_FRAMES);

    // Two missing lines trip the watchdog; clamp to what 11 bits can hold.
    localparam int          c_WDOG_LIMIT_INT = (2 * H_TOTAL > 2047) ? 2047 : 2 * H_TOTAL;
    localparam logic [10:0] c_WDOG_LIMIT     = 11'(c_WDOG_LIMIT_INT);
    localparam logic [10:0] c_WDOG_MAX       = 11'h7FF;

    // Lock state encoding.
    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_LOCKING  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED   = 2'd2;

    logic        r_hsync;
    logic        r_hsync_prev;
    logic        r_vsync;
    logic        r_vsync_prev;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [1:0]  r_state;
    logic [3:0]  r_good_cnt;
    logic [10:0] r_wdog;
    logic        r_line_err_seen;
    logic        r_frame_start;
    logic        r_sync_error;

    logic        w_h_fall;
    logic        w_v_fall;
    logic        w_col_at_last;
    logic        w_col_wrap;
    logic        w_row_wrap;
    logic [9:0]  w_col_next;
    logic [9:0]  w_row_next;
    logic        w_line_err;
    logic        w_frame_good;
    logic        w_frame_err;
    logic        w_wdog_trip;
    logic [1:0]  w_state_next;
    logic [3:0]  w_good_next;
    logic        w_sync_err_next;

    // Edge detect on the registered syncs; both stages idle high so reset never fakes an edge.
    assign w_h_fall = r_hsync_prev & ~r_hsync;
    assign w_v_fall = r_vsync_prev & ~r_vsync;

    // A natural column wrap only happens when no H fall reloads the counter.
    assign w_col_at_last = (r_col == c_H_LAST);
    assign w_col_wrap    = w_col_at_last & ~w_h_fall;
    assign w_row_wrap    = w_col_wrap & ~w_v_fall & (r_row == c_V_LAST);

    // An in-phase source drops HSync exactly when the free-running column sits one before sync start.
    assign w_line_err   = w_h_fall & (r_col != c_H_LINE_ALIGN);
    assign w_frame_good = w_v_fall & (r_row == c_V_SYNC_START) & ~r_line_err_seen & ~w_line_err;
    assign w_frame_err  = w_v_fall & ~w_frame_good;
    assign w_wdog_trip  = (r_wdog >= c_WDOG_LIMIT);

    // Counter next-values: sync edges reload, otherwise free-run with wrap.
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_h_fall) begin
            w_col_next = c_H_SYNC_START;
        end else if (w_col_at_last) begin
            w_col_next = 10'd0;
        end else begin
            w_col_next = r_col + 10'd1;
        end
        if (w_v_fall) begin
            w_row_next = c_V_SYNC_START;
        end else if (w_col_wrap) begin
            w_row_next = (r_row == c_V_LAST) ? 10'd0 : r_row + 10'd1;
        end
    end

    // Lock FSM next-state; the watchdog overrides every other transition.
    always_comb begin
        w_state_next    = r_state;
        w_good_next     = r_good_cnt;
        w_sync_err_next = 1'b0;
        if (w_wdog_trip) begin
            w_state_next = c_ST_UNLOCKED;
            w_good_next  = 4'd0;
        end else begin
            case (r_state)
                c_ST_UNLOCKED: begin
                    if (w_v_fall) begin
                        w_state_next = c_ST_LOCKING;
                        w_good_next  = 4'd0;
                    end
                end
                c_ST_LOCKING: begin
                    if (w_v_fall) begin
                        if (w_frame_good) begin
                            if (r_good_cnt + 4'd1 == c_LOCK_FRAMES) begin
                                w_state_next = c_ST_LOCKED;
                                w_good_next  = 4'd0;
                            end else begin
                                w_good_next = r_good_cnt + 4'd1;
                            end
                        end else begin
                            w_good_next = 4'd0;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    if (w_line_err | w_frame_err) begin
                        w_sync_err_next = 1'b1;
                        w_state_next    = c_ST_LOCKING;
                        w_good_next     = 4'd0;
                    end
                end
                default: begin
                    w_state_next = c_ST_UNLOCKED;
                    w_good_next  = 4'd0;
                end
            endcase
        end
    end

    // All state: sync pipeline, counters, watchdog, FSM and registered strobes.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_hsync         <= 1'b1;
            r_hsync_prev    <= 1'b1;
            r_vsync         <= 1'b1;
            r_vsync_prev    <= 1'b1;
            r_col           <= 10'd0;
            r_row           <= 10'd0;
            r_state         <= c_ST_UNLOCKED;
            r_good_cnt      <= 4'd0;
            r_wdog          <= 11'd0;
            r_line_err_seen <= 1'b0;
            r_frame_start   <= 1'b0;
            r_sync_error    <= 1'b0;
        end else begin
            r_hsync         <= i_VGA_HSync;
            r_hsync_prev    <= r_hsync;
            r_vsync         <= i_VGA_VSync;
            r_vsync_prev    <= r_vsync;
            r_col           <= w_col_next;
            r_row           <= w_row_next;
            r_state         <= w_state_next;
            r_good_cnt      <= w_good_next;
            r_sync_error    <= w_sync_err_next;
            r_frame_start   <= w_row_wrap & (w_state_next == c_ST_LOCKED);
            if (w_h_fall) begin
                r_wdog <= 11'd0;
            end else if (r_wdog != c_WDOG_MAX) begin
                r_wdog <= r_wdog + 11'd1;
            end
            // Line errors accumulate per frame and are judged at the next V fall.
            if (w_v_fall) begin
                r_line_err_seen <= 1'b0;
            end else if (w_line_err) begin
                r_line_err_seen <= 1'b1;
            end
        end
    end

    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Locked      = (r_state == c_ST_LOCKED);
    assign o_Visible     = o_Locked & (r_col < c_H_VISIBLE) & (r_row < c_V_VISIBLE);
    assign o_Frame_Start = r_frame_start;
    assign o_Sync_Error  = r_sync_error;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_decoder
//  Brief    : Self-checking bench for vga_sync_decoder using a scaled-down
//             raster. A source model drives the syncs; expected counters are
//             the source raster position delayed by three pixel clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int HV    = 16;
    localparam int VV    = 12;
    localparam int HT    = 32;
    localparam int VT    = 20;
    localparam int HFP   = 4;
    localparam int VFP   = 2;
    localparam int HSS   = HV + HFP;
    localparam int VSS   = VV + VFP;
    localparam int HSW   = 4;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs  = 1'b1;
    logic       vs  = 1'b1;
    logic [9:0] col;
    logic [9:0] row;
    logic       vis;
    logic       fs;
    logic       lk;
    logic       err;

    vga_sync_decoder #(
        .H_VISIBLE_AREA (HV),
        .V_VISIBLE_AREA (VV),
        .H_TOTAL        (HT),
        .V_TOTAL        (VT),
        .H_FRONT_PORCH  (HFP),
        .V_FRONT_PORCH  (VFP),
        .LOCK_FRAMES    (2)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_VGA_HSync   (hs),
        .i_VGA_VSync   (vs),
        .o_Col_Count   (col),
        .o_Row_Count   (row),
        .o_Visible     (vis),
        .o_Frame_Start (fs),
        .o_Locked      (lk),
        .o_Sync_Error  (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Source raster state and disturbance controls.
    int     src_col   = 0;
    int     src_row   = 0;
    int     src_vtot  = VT;
    int     early_row = -1;
    int     kill_lo   = -1;
    int     kill_hi   = -1;
    bit     src_on    = 1'b0;
    bit     pos_on    = 1'b0;

    // Observation bookkeeping.
    longint cyc     = 0;
    longint hf_last = -1;
    longint lk_rise = -1;
    longint lk_fall = -1;
    longint fs_last = -1;
    longint fs_gap  = 0;
    longint vf_cyc[$];
    int     vf_n    = 0;
    int     err_n   = 0;
    int     fs_n    = 0;
    int     vis_n   = 0;
    int     pos_bad = 0;
    bit     lk_prev = 1'b0;

    // The source registers its syncs, so each pulse starts one clock after its nominal column.
    function automatic bit h_pin(input int c, input int r);
        int s;
        s = (r == early_row) ? HSS + 1 - 5 : HSS + 1;
        if (r >= kill_lo && r <= kill_hi) return 1'b1;
        return !(c >= s && c < s + HSW);
    endfunction

    // VSync edges coincide with the HSync leading edge of the sync lines.
    function automatic bit v_pin(input int c, input int r);
        int lin;
        lin = r * HT + c;
        return !(lin >= VSS * HT + HSS + 1 && lin < (VSS + 2) * HT + HSS + 1);
    endfunction

    task automatic clear_stats();
        vf_n    = 0;
        vf_cyc.delete();
        err_n   = 0;
        fs_n    = 0;
        vis_n   = 0;
        pos_bad = 0;
        fs_last = -1;
        fs_gap  = 0;
        lk_fall = -1;
        lk_rise = -1;
    endtask

    // One pixel clock: observe outputs, compare against the raster model, drive the next sync values.
    task automatic tick();
        int mpos;
        int mc;
        int mr;
        int tot;
        bit nh;
        bit nv;
        @(posedge clk);
        #1;
        cyc++;
        if (err) err_n++;
        if (vis) vis_n++;
        if (fs) begin
            fs_n++;
            if (fs_last >= 0) fs_gap = cyc - fs_last;
            fs_last = cyc;
        end
        if (lk && !lk_prev) lk_rise = cyc;
        if (!lk && lk_prev) lk_fall = cyc;
        lk_prev = lk;
        if (pos_on) begin
            tot  = src_vtot * HT;
            mpos = (src_row * HT + src_col - 3 + tot) % tot;
            mc   = mpos % HT;
            mr   = mpos / HT;
            if (col !== 10'(mc) || row !== 10'(mr) || fs !== (mpos == 0) ||
                vis !== (mc < HV && mr < VV)) pos_bad++;
        end
        if (src_on) begin
            nh = h_pin(src_col, src_row);
            nv = v_pin(src_col, src_row);
            if (hs && !nh) hf_last = cyc;
            if (vs && !nv) begin
                vf_n++;
                vf_cyc.push_back(cyc);
            end
            hs = nh;
            vs = nv;
            src_col++;
            if (src_col == HT) begin
                src_col = 0;
                src_row++;
                if (src_row == src_vtot) src_row = 0;
            end
        end
    endtask

    task automatic wait_src(input int r, input int c);
        int i;
        i = 0;
        while (!(src_row == r && src_col == c) && i < 2 * FRAME) begin
            tick();
            i++;
        end
        if (i >= 2 * FRAME) check("wait_src_timeout", 1, 0);
    endtask

    // Lock is expected two clocks after the pin fall of the third VSync since stats were cleared.
    task automatic wait_lock(input string tag);
        longint exp;
        for (int i = 0; i < 6 * FRAME && lk_rise < 0; i++) tick();
        exp = (vf_cyc.size() >= 3) ? vf_cyc[2] + 2 : -2;
        check(tag, 32'(lk_rise), 32'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_col"},  32'(col), 0);
        check({tag, "_row"},  32'(row), 0);
        check({tag, "_lock"}, 32'(lk),  0);
        check({tag, "_vis"},  32'(vis), 0);
        check({tag, "_fs"},   32'(fs),  0);
        check({tag, "_err"},  32'(err), 0);
    endtask

    initial begin
        int     r;
        int     c;
        int     n;
        longint p;

        // Reset with idle syncs.
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Idle syncs after reset: counters free-run from zero, no lock.
        n = $urandom_range(5, 600);
        repeat (n) tick();
        check("idle_col", 32'(col), 32'(n % HT));
        check("idle_row", 32'(row), 32'(n / HT));
        check("idle_lock", 32'(lk), 0);

        // Clean stream from a random raster position.
        src_row  = $urandom_range(0, VV - 2);
        src_col  = $urandom_range(0, HT - 1);
        src_vtot = VT;
        clear_stats();
        src_on = 1'b1;
        wait_lock("lock_clean");

        clear_stats();
        pos_on = 1'b1;
        repeat (2 * FRAME) tick();
        check("clean_position", 32'(pos_bad), 0);
        check("clean_fs_count", 32'(fs_n), 2);
        check("clean_fs_gap", 32'(fs_gap), FRAME);
        check("clean_vis_count", 32'(vis_n), 2 * HV * VV);
        check("clean_err", 32'(err_n), 0);

        // One HSync pulse five clocks early.
        wait_src(0, 0);
        pos_on = 1'b0;
        clear_stats();
        r = $urandom_range(1, VV - 2);
        early_row = r;
        wait_src(r + 1, 0);
        early_row = -1;
        p = hf_last;
        wait_lock("relock_early");
        check("early_unlock_cycle", 32'(lk_fall), 32'(p + 2));
        check("early_err_pulses", 32'(err_n), 1);
        clear_stats();
        pos_on = 1'b1;
        repeat (FRAME) tick();
        check("early_rephase", 32'(pos_bad), 0);
        pos_on = 1'b0;

        // Three lines without HSync trip the watchdog.
        wait_src(0, 0);
        clear_stats();
        r = $urandom_range(1, VV - 4);
        kill_lo = r;
        kill_hi = r + 2;
        wait_src(r, 0);
        p = hf_last;
        wait_src(r + 3, 0);
        kill_lo = -1;
        kill_hi = -1;
        check("wdog_unlock_cycle", 32'(lk_fall), 32'(p + 2 * HT + 3));
        check("wdog_err", 32'(err_n), 0);
        check("wdog_lock", 32'(lk), 0);
        vis_n = 0;
        for (int i = 0; i < 2 * FRAME && vf_n < 1; i++) tick();
        check("wdog_vis", 32'(vis_n), 0);
        wait_lock("relock_wdog");

        // One-cycle reset mid-frame while locked.
        r = $urandom_range(1, VV - 3);
        c = $urandom_range(0, HT - 1);
        wait_src(r, c);
        check("pre_reset_lock", 32'(lk), 1);
        clear_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midreset");
        wait_lock("relock_reset");

        // Source one line short per frame: frame checks keep failing.
        src_vtot = VT - 1;
        src_row  = 0;
        src_col  = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_stats();
        repeat (8 * (VT - 1) * HT) tick();
        check("short_never_locked", 32'(lk_rise), 32'(-1));
        check("short_err", 32'(err_n), 0);
        check("short_vfalls", 32'(vf_n), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
